wb_host_arbiter: RTL and testbench

- Wishbone master-side controller that shares the single MAC register slave port among NREQ internal requesters, e.g. the config sequencer and the MII-management poller.
- Grants by round-robin and runs exactly one classic single-beat Wishbone cycle at a time.
- Returns read data, done and error status to the granted requester.
- Sits between the host-side requesters and the MAC wb_* slave pins.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/wb_host_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_host_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone host arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WB_ADR_W = 10;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first requester at or after the pointer, wrapping.
// The pointer moves past the granted requester when advance is strobed.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [NREQ-1:0] adv_gnt,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Requester j has priority rank i when j == (ptr + i) mod NREQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == (int'(ptr_q) + i) % NREQ) && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int j = 0; j < NREQ; j++) begin
        if (adv_gnt[j]) ptr_d = PW'((j + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_host_arbiter.sv
// Shares one Wishbone slave port among NREQ requesters, one classic cycle at a time.
// Optional WB_TIMEOUT_EN aborts a BUS cycle after TIMEOUT cycles without ack/err.
module wb_host_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          req_we_i,
  input  logic [NREQ*WB_ADR_W-1:0] req_adr_i,
  input  logic [NREQ*WB_DAT_W-1:0] req_dat_i,
  input  logic [NREQ*WB_SEL_W-1:0] req_sel_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          done_o,
  output logic                     err_o,
  output logic [WB_DAT_W-1:0]      rdata_o,
  output logic [WB_ADR_W-1:0]      wb_adr_o,
  output logic [WB_DAT_W-1:0]      wb_dat_o,
  output logic [WB_SEL_W-1:0]      wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic [WB_DAT_W-1:0]      wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("wb_host_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  state_e                state_q, state_d;
  logic [NREQ-1:0]       arb_gnt, gnt_q;
  logic                  we_q, pick_we;
  logic [WB_ADR_W-1:0]   adr_q, pick_adr;
  logic [WB_DAT_W-1:0]   dat_q, pick_dat, rdata_q;
  logic [WB_SEL_W-1:0]   sel_q, pick_sel;
  logic                  err_q;
  logic                  timeout_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .req     (req_i),
    .advance (state_q == RESP),
    .adv_gnt (gnt_q),
    .gnt     (arb_gnt)
  );

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] tmo_cnt_q;

  // Held at zero outside BUS so every cycle starts counting from entry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)             tmo_cnt_q <= '0;
    else if (state_q != BUS)   tmo_cnt_q <= '0;
    else                       tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == BUS) && (tmo_cnt_q == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    pick_we  = 1'b0;
    pick_adr = '0;
    pick_dat = '0;
    pick_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        pick_we  = req_we_i[k];
        pick_adr = req_adr_i[k*WB_ADR_W +: WB_ADR_W];
        pick_dat = req_dat_i[k*WB_DAT_W +: WB_DAT_W];
        pick_sel = req_sel_i[k*WB_SEL_W +: WB_SEL_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_i) state_d = BUS;
      BUS:     if (wb_ack_i || wb_err_i || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      gnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && |req_i) begin
        gnt_q <= arb_gnt;
        we_q  <= pick_we;
        adr_q <= pick_adr;
        dat_q <= pick_dat;
        sel_q <= pick_sel;
      end
      // err has priority over ack; read data is kept only on a clean read.
      if (state_q == BUS) begin
        if (wb_ack_i || wb_err_i) begin
          err_q <= wb_err_i;
          if (!wb_err_i && !we_q) rdata_q <= wb_dat_i;
        end else if (timeout_hit) begin
          err_q   <= 1'b1;
          rdata_q <= TIMEOUT_DATA;
        end
      end
    end
  end

  assign gnt_o    = (state_q == BUS)  ? gnt_q : '0;
  assign done_o   = (state_q == RESP) ? gnt_q : '0;
  assign err_o    = (state_q == RESP) && err_q;
  assign rdata_o  = rdata_q;
  assign wb_cyc_o = (state_q == BUS);
  assign wb_stb_o = (state_q == BUS);
  assign wb_we_o  = (state_q == BUS) && we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Self-checking bench for wb_host_arbiter: directed vector table, corner sequences,
// and randomized traffic against a round-robin reference model.
module tb_wb_host_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i;
  logic [NREQ-1:0]      req_i, req_we_i;
  logic [NREQ*10-1:0]   req_adr_i;
  logic [NREQ*32-1:0]   req_dat_i;
  logic [NREQ*4-1:0]    req_sel_i;
  logic [NREQ-1:0]      gnt_o, done_o;
  logic                 err_o;
  logic [31:0]          rdata_o;
  logic [9:0]           wb_adr_o;
  logic [31:0]          wb_dat_o;
  logic [3:0]           wb_sel_o;
  logic                 wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0]          wb_dat_i;
  logic                 wb_ack_i, wb_err_i;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_host_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .req_i (req_i), .req_we_i (req_we_i), .req_adr_i (req_adr_i),
    .req_dat_i (req_dat_i), .req_sel_i (req_sel_i),
    .gnt_o (gnt_o), .done_o (done_o), .err_o (err_o), .rdata_o (rdata_o),
    .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel_o),
    .wb_we_o (wb_we_o), .wb_stb_o (wb_stb_o), .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i), .wb_ack_i (wb_ack_i), .wb_err_i (wb_err_i)
  );

  typedef struct {
    int          k;
    logic        we;
    logic [9:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic        ack;
    logic        err;
    logic [31:0] sdat;
    logic        drop;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [9:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    req_we_i[k]          = we;
    req_adr_i[k*10 +: 10] = adr;
    req_dat_i[k*32 +: 32] = dat;
    req_sel_i[k*4 +: 4]   = sel;
    req_i[k]             = 1'b1;
  endtask

  // Advances at least one edge, then waits (bounded) for the bus cycle to open.
  task automatic wait_cyc(output int n);
    n = 0;
    tick();
    while (!wb_cyc_o && n < 50) begin
      tick();
      n++;
    end
    if (!wb_cyc_o) chk("cyc_wait_bound", 32'(wb_cyc_o), 32'd1);
  endtask

  // Slave side: hold off for waits cycles, then present the response for one edge.
  task automatic respond(input int waits, input logic ack, input logic err,
                         input logic [31:0] sdat, input int k, input logic drop);
    if (drop) req_i[k] = 1'b0;
    for (int w = 0; w < waits; w++) begin
      tick();
      chk("cyc_hold", 32'(wb_cyc_o), 32'd1);
    end
    wb_ack_i = ack;
    wb_err_i = err;
    wb_dat_i = sdat;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    req_i[k] = 1'b0;
  endtask

  task automatic do_vec(input vec_t v);
    int n;
    set_req(v.k, v.we, v.adr, v.dat, v.sel);
    wait_cyc(n);
    chk("latency",  32'(n),        32'd0);
    chk("gnt",      32'(gnt_o),    32'(1 << v.k));
    chk("stb",      32'(wb_stb_o), 32'd1);
    chk("adr",      32'(wb_adr_o), 32'(v.adr));
    chk("dat",      wb_dat_o,      v.dat);
    chk("sel",      32'(wb_sel_o), 32'(v.sel));
    chk("we",       32'(wb_we_o),  32'(v.we));
    respond(v.waits, v.ack, v.err, v.sdat, v.k, v.drop);
    chk("cyc_drop", 32'(wb_cyc_o), 32'd0);
    chk("done",     32'(done_o),   32'(1 << v.k));
    chk("gnt_clr",  32'(gnt_o),    32'd0);
    chk("err",      32'(err_o),    32'(v.exp_err));
    chk("rdata",    rdata_o,       v.exp_rdata);
    tick();
    chk("done_one", 32'(done_o),   32'd0);
  endtask

  initial begin
    int   n, nd, cyc, last, win, kind, waits;
    int   ptr_m;
    logic [31:0] rd_m, sdat;
    logic        pend[NREQ];
    logic        p_we[NREQ];
    logic [9:0]  p_adr[NREQ];
    logic [31:0] p_dat[NREQ];
    logic [3:0]  p_sel[NREQ];
    int          order[4];

    vecs[0] = '{0, 1'b1, 10'h010, 32'hA5A5_0001, 4'hF, 2, 1'b1, 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1] = '{1, 1'b0, 10'h004, 32'h0000_0000, 4'hF, 0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
    vecs[2] = '{0, 1'b0, 10'h3FF, 32'h0000_0000, 4'h3, 1, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0, 1'b1, 32'h1234_5678};
    vecs[3] = '{1, 1'b1, 10'h155, 32'hDEAD_C0DE, 4'h5, 3, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 32'h1234_5678};
    vecs[4] = '{0, 1'b0, 10'h2AA, 32'h0000_0000, 4'hC, 0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1, 1'b1, 10'h0F0, 32'h0102_0304, 4'h1, 0, 1'b1, 1'b0, 32'h7777_7777, 1'b1, 1'b0, 32'hCAFE_F00D};
    order = '{0, 1, 0, 1};

    wb_rst_i = 1'b0;
    req_i = '0; req_we_i = '0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

    #1;
    chk("rst_gnt",   32'(gnt_o),    32'd0);
    chk("rst_done",  32'(done_o),   32'd0);
    chk("rst_cyc",   32'(wb_cyc_o), 32'd0);
    chk("rst_stb",   32'(wb_stb_o), 32'd0);
    chk("rst_we",    32'(wb_we_o),  32'd0);
    chk("rst_err",   32'(err_o),    32'd0);
    chk("rst_rdata", rdata_o,       32'd0);
    chk("rst_adr",   32'(wb_adr_o), 32'd0);
    #12 wb_rst_i = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_vec(vecs[i]);

    // Slave responses outside BUS must be ignored.
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    tick();
    chk("idle_ack_cyc",  32'(wb_cyc_o), 32'd0);
    chk("idle_ack_done", 32'(done_o),   32'd0);
    tick();
    chk("idle_ack_done2", 32'(done_o),  32'd0);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;

    // Both requesters held: alternate 0,1,0,1 with zero-wait ack, 3 cycles apart.
    set_req(0, 1'b0, 10'h020, 32'd0, 4'hF);
    set_req(1, 1'b0, 10'h030, 32'd0, 4'hF);
    wb_dat_i = 32'h0000_1111;
    nd = 0; cyc = 0; last = 0;
    while (nd < 4 && cyc < 40) begin
      tick();
      cyc++;
      wb_ack_i = wb_cyc_o;
      if (done_o != '0) begin
        chk("rr_order", 32'(done_o), 32'(1 << order[nd]));
        if (nd > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        nd++;
      end
    end
    chk("rr_count", 32'(nd), 32'd4);
    req_i = '0; wb_ack_i = 1'b0;
    tick();

    // Move the pointer to 1, then reset in the middle of a cycle granted to requester 1.
    do_vec('{0, 1'b1, 10'h001, 32'h0000_0011, 4'hF, 0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0000_1111});
    set_req(0, 1'b1, 10'h001, 32'h0000_0022, 4'hF);
    set_req(1, 1'b0, 10'h002, 32'd0, 4'hF);
    wait_cyc(n);
    chk("pre_rst_gnt", 32'(gnt_o), 32'b10);
    #2 wb_rst_i = 1'b0;
    #1;
    chk("mid_rst_cyc",  32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb",  32'(wb_stb_o), 32'd0);
    chk("mid_rst_gnt",  32'(gnt_o),    32'd0);
    chk("mid_rst_done", 32'(done_o),   32'd0);
    tick();
    chk("mid_rst_done2", 32'(done_o),  32'd0);
    #3 wb_rst_i = 1'b1;
    wait_cyc(n);
    chk("post_rst_gnt", 32'(gnt_o), 32'b01);
    chk("post_rst_adr", 32'(wb_adr_o), 32'h001);
    respond(0, 1'b1, 1'b0, 32'hFEED_0000, 0, 1'b0);
    chk("post_rst_done", 32'(done_o), 32'b01);
    req_i[1] = 1'b0;
    tick();

    // Randomized traffic against the round-robin model.
    ptr_m = 1;
    rd_m  = 32'd0;
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k]  = 1'b1;
          p_we[k]  = 1'($urandom_range(0, 1));
          p_adr[k] = 10'($urandom);
          p_dat[k] = $urandom;
          p_sel[k] = 4'($urandom);
          set_req(k, p_we[k], p_adr[k], p_dat[k], p_sel[k]);
        end
      end
      win = -1;
      for (int k = 0; k < NREQ; k++) if (pend[k]) win = k;
      if (win < 0) begin
        win = $urandom_range(0, NREQ - 1);
        pend[win] = 1'b1; p_we[win] = 1'b0; p_adr[win] = 10'h3C3;
        p_dat[win] = 32'd0; p_sel[win] = 4'hF;
        set_req(win, p_we[win], p_adr[win], p_dat[win], p_sel[win]);
      end
      win = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (win < 0 && pend[(ptr_m + i) % NREQ]) win = (ptr_m + i) % NREQ;
      end
      wait_cyc(n);
      chk("rnd_gnt", 32'(gnt_o), 32'(1 << win));
      chk("rnd_adr", 32'(wb_adr_o), 32'(p_adr[win]));
      chk("rnd_we",  32'(wb_we_o),  32'(p_we[win]));
      if (p_we[win]) chk("rnd_dat", wb_dat_o, p_dat[win]);
      waits = $urandom_range(0, 3);
      kind  = $urandom_range(0, 2);
      sdat  = $urandom;
      if (kind == 0 && !p_we[win]) rd_m = sdat;
      respond(waits, kind != 1, kind != 0, sdat, win, $urandom_range(0, 3) == 0);
      chk("rnd_done",  32'(done_o), 32'(1 << win));
      chk("rnd_err",   32'(err_o),  32'(kind != 0));
      chk("rnd_rdata", rdata_o,     rd_m);
      pend[win] = 1'b0;
      ptr_m = (win + 1) % NREQ;
      tick();
    end
    req_i = '0;

`ifdef WB_TIMEOUT_EN
    set_req(0, 1'b0, 10'h040, 32'd0, 4'hF);
    wait_cyc(n);
    cyc = 1;
    while (wb_cyc_o && cyc < 40) begin
      tick();
      if (wb_cyc_o) cyc++;
    end
    chk("tmo_bus_cycles", 32'(cyc),    32'd16);
    chk("tmo_done",       32'(done_o), 32'b01);
    chk("tmo_err",        32'(err_o),  32'd1);
    chk("tmo_rdata",      rdata_o,     32'hDEAD_BEEF);
    req_i = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
